// File: rtl/tpu_axi_pkg.sv
// tpu_axi_pkg: FSM states and AXI constants shared by the TPU AXI masters.
package tpu_axi_pkg;
   typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_4KB        = 4096;
   function automatic logic [2:0] AXI_SIZE_FN(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction
endpackage

// File: rtl/tpu_axi_burst_calc.sv
// tpu_axi_burst_calc: ARLEN for the next burst, limited by words left, max burst and 4KB page.
module tpu_axi_burst_calc
   import tpu_axi_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16,
   parameter int CNT_W     = 9
) (
   input  logic [11:0]      i_addr_lo,
   input  logic [CNT_W-1:0] i_rem,
   output logic [7:0]       o_len
);
   localparam int SZ = AXI_SIZE_FN(DATA_W);
   logic [12:0] w_room, w_rem, w_b1, w_beats;
   assign w_room  = (13'(AXI_4KB) - {1'b0, i_addr_lo}) >> SZ;
   assign w_rem   = 13'(i_rem);
   assign w_b1    = (w_rem < 13'(BURST_LEN)) ? w_rem : 13'(BURST_LEN);
   assign w_beats = (w_b1 < w_room) ? w_b1 : w_room;
   assign o_len   = 8'(w_beats - 13'd1);
endmodule

// File: rtl/tpu_axi4_matrix_reader.sv
// tpu_axi4_matrix_reader: AXI4 read master that fetches an operand matrix into a TPU word buffer.
module tpu_axi4_matrix_reader
   import tpu_axi_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_BURST_LEN  = 16,
   parameter int MAX_MATRIX_SIZE    = 16,
   parameter int BUF_ADDR_WIDTH     = 8
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic                          start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
   input  logic [BUF_ADDR_WIDTH:0]       num_words,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARLOCK,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic [3:0]                    M_AXI_ARQOS,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY,
   output logic                          buf_we,
   output logic [BUF_ADDR_WIDTH-1:0]     buf_addr,
   output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wdata
);
   localparam int AW   = C_M_AXI_ADDR_WIDTH;
   localparam int CW   = BUF_ADDR_WIDTH + 1;
   localparam int NB   = C_M_AXI_DATA_WIDTH / 8;
   localparam int SZ   = AXI_SIZE_FN(C_M_AXI_DATA_WIDTH);
   localparam int MAXW = MAX_MATRIX_SIZE * MAX_MATRIX_SIZE;
   state_t                        r_state;
   logic [AW-1:0]                 r_addr;
   logic [CW-1:0]                 r_rem;
   logic [BUF_ADDR_WIDTH-1:0]     r_cnt, r_baddr;
   logic [7:0]                    r_len, r_beat;
   logic                          r_err, r_busy, r_done, r_arvalid, r_rready, r_we;
   logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [7:0]                    w_len;
   logic [CW-1:0]                 w_nw;
   logic [AW-1:0]                 w_bytes;
   logic                          w_last, w_err, w_more, w_unused;
   tpu_axi_burst_calc #(
      .DATA_W   (C_M_AXI_DATA_WIDTH),
      .BURST_LEN(C_M_AXI_BURST_LEN),
      .CNT_W    (CW)
   ) u_calc (
      .i_addr_lo(r_addr[11:0]),
      .i_rem    (r_rem),
      .o_len    (w_len)
   );
   assign w_nw     = (num_words > CW'(MAXW)) ? CW'(MAXW) : num_words;
   assign w_bytes  = (AW'(r_len) + 1'b1) << SZ;
   assign w_last   = r_beat == r_len;
   // A beat-count/RLAST disagreement is an error, but the burst still ends on the count.
   assign w_err    = r_err | (M_AXI_RRESP != AXI_RESP_OKAY) | (M_AXI_RLAST != w_last);
   assign w_more   = (r_rem != CW'(1)) && !w_err;
   assign w_unused = &{1'b0, M_AXI_RID};
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state   <= S_IDLE;
         r_addr    <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_baddr   <= '0;
         r_len     <= '0;
         r_beat    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_we      <= 1'b0;
         r_wdata   <= '0;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (start && !r_done) begin
               r_addr    <= src_addr & ~AW'(NB - 1);
               r_rem     <= w_nw;
               r_cnt     <= '0;
               r_err     <= 1'b0;
               r_busy    <= 1'b1;
               r_arvalid <= w_nw != '0;
               r_state   <= (w_nw == '0) ? S_DONE : S_AR;
            end
            S_AR: if (M_AXI_ARREADY) begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b1;
               r_len     <= w_len;
               r_beat    <= '0;
               r_state   <= S_R;
            end
            S_R: if (M_AXI_RVALID) begin
               r_we    <= 1'b1;
               r_baddr <= r_cnt;
               r_wdata <= M_AXI_RDATA;
               r_cnt   <= r_cnt + 1'b1;
               r_rem   <= r_rem - 1'b1;
               r_beat  <= r_beat + 8'd1;
               r_err   <= w_err;
               if (w_last) begin
                  r_rready  <= 1'b0;
                  r_addr    <= r_addr + w_bytes;
                  r_arvalid <= w_more;
                  r_state   <= w_more ? S_AR : S_DONE;
               end
            end
            default: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
   assign busy          = r_busy;
   assign done          = r_done;
   assign error         = r_err;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARADDR  = r_addr;
   assign M_AXI_ARLEN   = r_arvalid ? w_len : 8'd0;
   assign M_AXI_ARSIZE  = AXI_SIZE_FN(C_M_AXI_DATA_WIDTH);
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = 4'b0011;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'd0;
   assign M_AXI_ARVALID = r_arvalid;
   assign M_AXI_RREADY  = r_rready;
   assign buf_we        = r_we;
   assign buf_addr      = r_baddr;
   assign buf_wdata     = r_wdata;
endmodule
